// File: rtl/v_shifter_pipelined.sv
// Pipelined shifter: stage k shifts by 2^k when SH[k] is set, with a sticky discard flag.
// The whole pipeline stalls as one unit when the output is valid but not accepted.
module v_shifter_pipelined #(
  parameter int WIDTH = 8,
  parameter int SHW   = 3
) (
  input  logic             C,
  input  logic             CLR,
  input  logic [WIDTH-1:0] DI,
  input  logic [SHW-1:0]   SH,
  input  logic [1:0]       MODE,
  input  logic             IVLD,
  output logic             IRDY,
  output logic [WIDTH-1:0] SO,
  output logic             CO,
  output logic             OVLD,
  input  logic             ORDY
);

  localparam logic [1:0] MODE_LSL = 2'b00;
  localparam logic [1:0] MODE_LSR = 2'b01;
  localparam logic [1:0] MODE_ASR = 2'b10;
  localparam logic [1:0] MODE_ROL = 2'b11;

  logic [WIDTH-1:0] data_q [SHW];
  logic [WIDTH-1:0] data_d [SHW];
  logic [SHW-1:0]   sh_q   [SHW];
  logic [SHW-1:0]   sh_d   [SHW];
  logic [1:0]       mode_q [SHW];
  logic [1:0]       mode_d [SHW];
  logic             flag_q [SHW];
  logic             flag_d [SHW];
  logic             vld_q  [SHW];
  logic             vld_d  [SHW];
  logic             en;

  // Returns {discard_or, shifted_data} for one fixed power-of-two shift.
  function automatic logic [WIDTH:0] shift_stage(input logic [WIDTH-1:0] d,
                                                 input logic [1:0] m,
                                                 input int amt);
    logic [WIDTH-1:0] ones;
    logic [WIDTH-1:0] res;
    logic             disc;
    ones = '1;
    res  = d;
    disc = 1'b0;
    case (m)
      MODE_LSL: begin
        res  = d << amt;
        disc = |(d & ~(ones >> amt));
      end
      MODE_LSR: begin
        res  = d >> amt;
        disc = |(d & ~(ones << amt));
      end
      MODE_ASR: begin
        // MSB doubles as the sign since arithmetic right never changes it
        res  = $signed(d) >>> amt;
        disc = |(d & ~(ones << amt));
      end
      MODE_ROL: begin
        res  = (d << amt) | (d >> (WIDTH - amt));
        disc = 1'b0;
      end
      default: ;
    endcase
    return {disc, res};
  endfunction

  assign en   = ~vld_q[SHW-1] | ORDY;
  assign IRDY = en & ~CLR;
  assign SO   = data_q[SHW-1];
  assign CO   = flag_q[SHW-1];
  assign OVLD = vld_q[SHW-1];

  always_comb begin
    logic [WIDTH-1:0] src_data;
    logic [SHW-1:0]   src_sh;
    logic [1:0]       src_mode;
    logic             src_flag;
    logic             src_vld;
    logic [WIDTH:0]   stage_out;
    for (int k = 0; k < SHW; k++) begin
      data_d[k] = data_q[k];
      sh_d[k]   = sh_q[k];
      mode_d[k] = mode_q[k];
      flag_d[k] = flag_q[k];
      vld_d[k]  = vld_q[k];
      if (k == 0) begin
        src_data = DI;
        src_sh   = SH;
        src_mode = MODE;
        src_flag = 1'b0;
        src_vld  = IVLD;
      end else begin
        src_data = data_q[k-1];
        src_sh   = sh_q[k-1];
        src_mode = mode_q[k-1];
        src_flag = flag_q[k-1];
        src_vld  = vld_q[k-1];
      end
      stage_out = shift_stage(src_data, src_mode, 1 << k);
      if (en) begin
        sh_d[k]   = src_sh;
        mode_d[k] = src_mode;
        vld_d[k]  = src_vld;
        if (src_sh[k]) begin
          data_d[k] = stage_out[WIDTH-1:0];
          flag_d[k] = src_flag | stage_out[WIDTH];
        end else begin
          data_d[k] = src_data;
          flag_d[k] = src_flag;
        end
      end
    end
  end

  always_ff @(posedge C or posedge CLR) begin
    if (CLR) begin
      for (int k = 0; k < SHW; k++) begin
        data_q[k] <= '0;
        sh_q[k]   <= '0;
        mode_q[k] <= '0;
        flag_q[k] <= 1'b0;
        vld_q[k]  <= 1'b0;
      end
    end else begin
      for (int k = 0; k < SHW; k++) begin
        data_q[k] <= data_d[k];
        sh_q[k]   <= sh_d[k];
        mode_q[k] <= mode_d[k];
        flag_q[k] <= flag_d[k];
        vld_q[k]  <= vld_d[k];
      end
    end
  end

endmodule

// File: tb/tb_v_shifter_pipelined.sv
// Directed-vector and stream bench for v_shifter_pipelined (WIDTH=8, SHW=3).
module tb_v_shifter_pipelined;
  localparam int WIDTH = 8;
  localparam int SHW   = 3;

  logic             C = 1'b0;
  logic             CLR = 1'b1;
  logic [WIDTH-1:0] DI = '0;
  logic [SHW-1:0]   SH = '0;
  logic [1:0]       MODE = '0;
  logic             IVLD = 1'b0;
  logic             IRDY;
  logic [WIDTH-1:0] SO;
  logic             CO;
  logic             OVLD;
  logic             ORDY = 1'b1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [7:0] di;
    logic [2:0] sh;
    logic [1:0] mode;
    logic [7:0] so;
    logic       co;
  } vec_t;

  vec_t vecs[15];
  vec_t stream_q[$];

  always #5 C = ~C;

  v_shifter_pipelined #(.WIDTH(WIDTH), .SHW(SHW)) dut (
    .C(C), .CLR(CLR), .DI(DI), .SH(SH), .MODE(MODE), .IVLD(IVLD), .IRDY(IRDY),
    .SO(SO), .CO(CO), .OVLD(OVLD), .ORDY(ORDY)
  );

  task automatic step();
    @(posedge C);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Whole-shift reference in a double-width window; independent of the staged structure.
  function automatic vec_t ref_vec(input logic [7:0] di, input logic [2:0] sh, input logic [1:0] m);
    vec_t v;
    logic [15:0] w;
    v.di = di; v.sh = sh; v.mode = m;
    case (m)
      2'b00: begin w = {8'h00, di} << sh; v.so = w[7:0]; v.co = |w[15:8]; end
      2'b01: begin w = {di, 8'h00} >> sh; v.so = w[15:8]; v.co = |w[7:0]; end
      2'b10: begin w = $signed({di, 8'h00}) >>> sh; v.so = w[15:8]; v.co = |w[7:0]; end
      default: begin w = {di, di} << sh; v.so = w[15:8]; v.co = 1'b0; end
    endcase
    return v;
  endfunction

  task automatic run_single(input vec_t v);
    int lat;
    DI = v.di; SH = v.sh; MODE = v.mode; IVLD = 1'b1; ORDY = 1'b1;
    #1;
    chk("single_irdy", IRDY, 1);
    step();
    IVLD = 1'b0;
    lat = 0;
    while (!OVLD && lat < 10) begin
      step();
      lat++;
    end
    chk("single_latency", lat, SHW - 1);
    chk("single_so", SO, v.so);
    chk("single_co", CO, v.co);
    $display("txn di=%02h sh=%0d mode=%0d so=%02h co=%0d", v.di, v.sh, v.mode, SO, CO);
    step();
    chk("single_ovld_pulse", OVLD, 0);
  endtask

  // Streams stream_q through the DUT and scoreboards outputs in order.
  task automatic run_stream(input bit stall_first, input bit rand_ordy);
    int n, sent, got, cyc, stall_left, extra;
    bit stalled_once;
    n = stream_q.size();
    sent = 0; got = 0; cyc = 0; stall_left = 0; stalled_once = 0;
    while (got < n && cyc < 500) begin
      if (sent < n) begin
        DI = stream_q[sent].di; SH = stream_q[sent].sh; MODE = stream_q[sent].mode;
        IVLD = 1'b1;
      end else begin
        IVLD = 1'b0;
      end
      if (stall_first && OVLD && !stalled_once) begin
        stall_left = 3;
        stalled_once = 1;
      end
      if (stall_left > 0) ORDY = 1'b0;
      else if (rand_ordy) ORDY = 1'($urandom_range(0, 1));
      else ORDY = 1'b1;
      #1;
      if (stall_left > 0) begin
        chk("stall_so", SO, stream_q[got].so);
        chk("stall_irdy", IRDY, 0);
        chk("stall_ovld", OVLD, 1);
        stall_left--;
      end
      if (OVLD && ORDY) begin
        chk("stream_so", SO, stream_q[got].so);
        chk("stream_co", CO, stream_q[got].co);
        $display("txn out#%0d so=%02h co=%0d", got, SO, CO);
        got++;
      end
      if (IVLD && IRDY) sent++;
      step();
      cyc++;
    end
    chk("stream_count", got, n);
    IVLD = 1'b0; ORDY = 1'b1;
    extra = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      if (OVLD) extra++;
    end
    chk("stream_no_extra", extra, 0);
  endtask

  initial begin
    int spurious;
    vecs[0]  = '{8'h96, 3'd3, 2'b00, 8'hB0, 1'b1};
    vecs[1]  = '{8'h96, 3'd2, 2'b10, 8'hE5, 1'b1};
    vecs[2]  = '{8'h96, 3'd0, 2'b01, 8'h96, 1'b0};
    vecs[3]  = '{8'h96, 3'd5, 2'b11, 8'hD2, 1'b0};
    vecs[4]  = '{8'h01, 3'd7, 2'b11, 8'h80, 1'b0};
    vecs[5]  = '{8'h96, 3'd0, 2'b00, 8'h96, 1'b0};
    vecs[6]  = '{8'h96, 3'd0, 2'b10, 8'h96, 1'b0};
    vecs[7]  = '{8'h80, 3'd7, 2'b01, 8'h01, 1'b0};
    vecs[8]  = '{8'h80, 3'd7, 2'b10, 8'hFF, 1'b0};
    vecs[9]  = '{8'h81, 3'd1, 2'b00, 8'h02, 1'b1};
    vecs[10] = '{8'h7F, 3'd4, 2'b10, 8'h07, 1'b1};
    vecs[11] = '{8'h0F, 3'd4, 2'b00, 8'hF0, 1'b0};
    vecs[12] = '{8'h96, 3'd1, 2'b01, 8'h4B, 1'b0};
    vecs[13] = '{8'h01, 3'd1, 2'b01, 8'h00, 1'b1};
    vecs[14] = '{8'hA5, 3'd4, 2'b11, 8'h5A, 1'b0};

    // Reset state
    step();
    step();
    chk("rst_so", SO, 0);
    chk("rst_co", CO, 0);
    chk("rst_ovld", OVLD, 0);
    chk("rst_irdy", IRDY, 0);
    CLR = 1'b0;
    step();
    chk("post_rst_irdy", IRDY, 1);

    foreach (vecs[i]) run_single(vecs[i]);

    // Back-pressure: six back-to-back LSL-by-1, stall three cycles at first output
    stream_q.delete();
    for (int i = 1; i <= 6; i++)
      stream_q.push_back('{8'(i), 3'd1, 2'b00, 8'(2 * i), 1'b0});
    run_stream(1'b1, 1'b0);

    // Reset mid-stream with one result on the output and one still in flight
    DI = 8'h11; SH = 3'd1; MODE = 2'b00; IVLD = 1'b1; ORDY = 1'b1;
    step();
    DI = 8'h22;
    step();
    IVLD = 1'b0;
    step();
    chk("pre_clr_ovld", OVLD, 1);
    #1 CLR = 1'b1;
    #1;
    chk("clr_ovld", OVLD, 0);
    chk("clr_so", SO, 0);
    chk("clr_co", CO, 0);
    chk("clr_irdy", IRDY, 0);
    #1 CLR = 1'b0;
    step();
    chk("clr_release_irdy", IRDY, 1);
    spurious = 0;
    for (int i = 0; i < 5; i++) begin
      if (OVLD) spurious++;
      step();
    end
    chk("clr_no_output", spurious, 0);

    // Sweep every MODE/SH pair with random data and random back-pressure
    stream_q.delete();
    for (int m = 0; m < 4; m++)
      for (int s = 0; s < 8; s++)
        stream_q.push_back(ref_vec(8'($urandom), 3'(s), 2'(m)));
    run_stream(1'b0, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/v_shifter_pipelined.md
# v_shifter_pipelined

Parametrised, pipelined shifter with four shift modes and a valid/ready handshake on input and output. It takes a WIDTH-bit operand, a shift amount and a mode, and returns the shifted result plus a carry-out flag. Latency is one clock per shift-amount bit. It sits on datapath streams that need run-time-selectable shifts at full clock rate, including under downstream back-pressure.

## Interface
- WIDTH, 8: operand/result width. Must be a power of two, ≥ 2.
- SHW, 3: shift-amount width. Must equal log2(WIDTH). It is also the pipeline depth.
- C  input  1  clock; all state changes on rising edge.
- CLR  input  1  asynchronous, active-high reset.
- DI  input  WIDTH  operand.
- SH  input  SHW  shift amount, 0..WIDTH-1.
- MODE  input  2  00 logical left, 01 logical right, 10 arithmetic right, 11 rotate left.
- IVLD  input  1  DI/SH/MODE valid.
- IRDY  output  1  block can accept input this cycle.
- SO  output  WIDTH  shifted result.
- CO  output  1  OR of all bits discarded by the shift. Always 0 in rotate mode.
- OVLD  output  1  SO/CO valid.
- ORDY  input  1  downstream accepts SO/CO this cycle.

## Operation
- Input is accepted on a rising edge when IVLD & IRDY. Output is consumed on a rising edge when OVLD & ORDY.
- The pipeline has SHW registered stages, k = 0..SHW-1. Stage k applies a shift of 2^k when the captured SH[k] = 1, and passes data unchanged otherwise.
- Each stage holds: data, valid bit, mode, and a sticky discard flag. The sign bit is not carried separately: the data MSB is the sign for arithmetic right, because arithmetic right preserves it.
- Fill rules per stage:
  - Logical left: zeros into the LSBs. Discarded bits are the top 2^k.
  - Logical right: zeros into the MSBs. Discarded bits are the low 2^k.
  - Arithmetic right: copies of the current MSB into the MSBs. Discarded bits are the low 2^k.
  - Rotate left: bits leaving the top re-enter at the bottom. Nothing is discarded.
- Discard flag: stage k output flag = previous flag | (OR of the bits discarded at stage k). The flag is 0 entering stage 0. CO is the last stage's flag.
- SH = 0 gives SO = DI and CO = 0 in every mode.
- Stall is global. Advance enable EN = ~OVLD | ORDY.
  - EN = 1: every stage loads from its predecessor. Stage 0 loads the input, with valid = IVLD.
  - EN = 0: every stage holds.
- IRDY = EN. IRDY is forced to 0 while CLR = 1.
- Bubbles (invalid stages) advance like data. No bubble squeezing.
- No transaction is dropped or duplicated. Output order equals acceptance order.
- SO, CO and OVLD are driven directly from last-stage registers; there is no combinational path from DI to SO.

## Timing
- Reset: all stage data, mode, flag and valid registers clear to 0 asynchronously on CLR = 1.
  - Outputs in reset: SO = 0, CO = 0, OVLD = 0, IRDY = 0.
  - First edge after CLR deasserts: IRDY = 1.
- Latency: a transaction accepted at edge n appears with OVLD = 1 after edge n+SHW-1 (valid from cycle n+SHW-1 to n+SHW), provided there is no stall. This is SHW edges counting the acceptance edge.
- Throughput: one transaction per cycle while ORDY = 1.
- ORDY low with OVLD high: SO, CO, OVLD and all stage contents hold; IRDY = 0 in the same cycle. An IVLD presented then is not accepted and must be held by the source.
- ORDY low with OVLD low: the pipeline still advances, so bubbles are absorbed.
- Simultaneous output consume and input accept in one cycle is legal and loses nothing.
- CLR mid-operation: all in-flight transactions are discarded immediately. No result for them ever appears.
- MODE/SH/DI are sampled only on the accept edge; later changes do not affect in-flight data.

## Test plan
- WIDTH=8, DI=8'h96, SH=3, MODE=00, ORDY=1 → after 3 edges: SO=8'hB0, CO=1, OVLD high for exactly 1 cycle.
- DI=8'h96, SH=2, MODE=10 → SO=8'hE5, CO=1. Then DI=8'h96, SH=0, MODE=01 → SO=8'h96, CO=0.
- DI=8'h96, SH=5, MODE=11 → SO=8'hD2, CO=0. DI=8'h01, SH=7, MODE=11 → SO=8'h80, CO=0.
- Back-pressure:
  - Stimulus: 6 back-to-back inputs (DI = 1..6, SH=1, MODE=00); ORDY low for 3 cycles starting at first OVLD.
  - Required: SO=8'h02 held stable, IRDY=0 during the stall; outputs 2,4,6,8,10,12 in order with none lost or duplicated.
- Reset mid-stream: 2 transactions in flight, pulse CLR for 1 cycle between edges → OVLD=0, SO=0 immediately; no output appears in the following 5 cycles; IRDY=1 after the first edge post-release.
- Random sweep: all MODE/SH combinations and random DI with random ORDY → SO/CO match the reference model and ordering is preserved.
